adsr_env: RTL and testbench
===========================

Name: adsr_env

Overview:
- Envelope generator directly downstream of the SPI configuration register; consumes adsr_ai, adsr_di, adsr_s, adsr_ri, trig and mute.
- Produces an 8-bit ADSR envelope from a 16-bit accumulator stepped on an internal prescaled tick.
- Scales the oscillator sample by the envelope before it reaches the filter.

Parameters:
- PRESCALE, 256, clocks per envelope tick; must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- gate  in  1  note-on level; driven from trig or an external key
- mute  in  1  forces envelope and sample_out to 0 (high during SPI programming)
- adsr_ai  in  8  attack increment per tick
- adsr_di  in  8  decay decrement per tick
- adsr_s  in  8  sustain level (upper byte of accumulator)
- adsr_ri  in  8  release decrement per tick
- sample_in  in  8  unsigned oscillator sample
- sample_out  out  8  unsigned scaled sample, registered
- env  out  8  envelope level = acc[15:8]
- active  out  1  high when state != IDLE
- state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: acc=0, state=IDLE, gate_q=0, prescaler=0, sample_out=0. Therefore env=0 and active=0.
- Prescaler:
  - Free-running counter 0..PRESCALE-1.
  - tick=1 in the cycle where count==PRESCALE-1.
  - Cleared only by rst; unaffected by mute.
- Priority, evaluated each clk: rst > mute > gate rising edge > gate low > tick update.
- gate_q:
  - Registers gate every cycle.
  - Rising edge = gate & ~gate_q.
  - While mute=1, gate_q is forced 0, so a gate held high through mute retriggers when mute drops.
- mute=1: state<=IDLE, acc<=0, sample_out<=0.
- Gate rising edge, from any state: state<=ATTACK; acc unchanged (retrigger from current level). Applies even if tick=1 in the same cycle; no accumulator step that cycle.
- Gate low in ATTACK, DECAY or SUSTAIN: state<=RELEASE on the next clk, independent of tick. acc unchanged that cycle.
- Tick updates (gate high, no edge):
  - ATTACK: sum = acc + ai (17-bit).
    - If sum >= 16'hFFFF: acc<=16'hFFFF and state<=DECAY.
    - Else acc<=sum.
    - ai=0 holds the level.
  - DECAY: target = {adsr_s, 8'h00}.
    - If acc <= target + di (compare with borrow, no wrap): acc<=target and state<=SUSTAIN.
    - Else acc<=acc-di.
    - di=0 holds the level.
  - SUSTAIN: acc<={adsr_s, 8'h00} every tick, so it tracks reprogramming.
- RELEASE tick (gate low):
  - If acc <= ri: acc<=0 and state<=IDLE.
  - Else acc<=acc-ri.
  - ri=0 holds the level until the next gate edge.
- IDLE: acc held at 0.
- Arithmetic:
  - Increments are zero-extended 8-bit values.
  - No wrap-around in any direction; saturate or clamp at the bounds above.
- Outputs:
  - env is combinational from the acc register.
  - sample_out <= (sample_in * env) >> 8 when mute=0; 16-bit product, upper byte, 1-cycle latency.
- Reset asserted mid-envelope returns all state to reset values on that edge.

Test Plan (PRESCALE=4):
- Reset, then gate=0 for 100 clocks -> env=0, state=0, active=0, sample_out=0 throughout.
- Attack: ai=8'h80, gate rises -> state=1 next clk; env first reads 8'hFF at tick 510; acc=16'hFFFF and state=2 at tick 512.
- Decay: di=8'h40, s=8'h80 -> after 511 decay ticks acc=16'h803F; tick 512 clamps acc to 16'h8000, state=3, env=8'h80.
- Release:
  - Drop gate -> state=4 next clk.
  - ri=8'hFF from 16'h8000 -> acc=16'h0080 after 128 ticks.
  - Tick 129 -> acc=0, state=0, active=0.
- Retrigger and scaling:
  - Gate rises mid-release at env=8'h40 -> state=1 with env still 8'h40 (no reset to 0).
  - sample_in=8'hFF at env=8'h80 -> sample_out=8'h7F one clk later.
- Mute and reset mid-note:
  - mute=1 during SUSTAIN with gate held -> env=0, state=0, sample_out=0 next clk.
  - mute=0 -> ATTACK restarts.
  - rst asserted mid-ATTACK -> all reset values on that edge.

Source files
------------

// File: rtl/adsr_env.sv
// adsr_env: ADSR envelope generator on a prescaled tick, scaling the oscillator sample by the envelope.
module adsr_env #(
  parameter int PRESCALE = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gate,
  input  logic       mute,
  input  logic [7:0] adsr_ai,
  input  logic [7:0] adsr_di,
  input  logic [7:0] adsr_s,
  input  logic [7:0] adsr_ri,
  input  logic [7:0] sample_in,
  output logic [7:0] sample_out,
  output logic [7:0] env,
  output logic       active,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
  localparam int CW = $clog2(PRESCALE);
  state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d, target, prod;
  logic [16:0] sum, lim;
  logic [7:0] sample_q, sample_d;
  logic gate_q, gate_d, tick, rise;
  assign env = acc_q[15:8];
  assign active = st_q != IDLE;
  assign state = st_q;
  assign sample_out = sample_q;
  always_comb begin
    tick = cnt_q == CW'(PRESCALE - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    rise = gate & ~gate_q;
    gate_d = gate & ~mute;
    target = {adsr_s, 8'h00};
    sum = {1'b0, acc_q} + {9'h0, adsr_ai};
    lim = {1'b0, target} + {9'h0, adsr_di};
    prod = sample_in * env;
    sample_d = mute ? '0 : prod[15:8];
    st_d = st_q;
    acc_d = acc_q;
    if (mute) begin
      st_d = IDLE;
      acc_d = '0;
    end else if (rise) begin
      st_d = ATTACK;
    end else if (!gate) begin
      if (st_q == ATTACK || st_q == DECAY || st_q == SUSTAIN) begin
        st_d = RELEASE;
      end else if (tick && st_q == RELEASE) begin
        st_d = (acc_q <= {8'h0, adsr_ri}) ? IDLE : RELEASE;
        acc_d = (acc_q <= {8'h0, adsr_ri}) ? '0 : acc_q - {8'h0, adsr_ri};
      end
    end else if (tick) begin
      case (st_q)
        ATTACK: begin
          st_d = (sum >= 17'h0FFFF) ? DECAY : ATTACK;
          acc_d = (sum >= 17'h0FFFF) ? 16'hFFFF : sum[15:0];
        end
        DECAY: begin
          // compare in 17 bits so target + di cannot wrap
          st_d = ({1'b0, acc_q} <= lim) ? SUSTAIN : DECAY;
          acc_d = ({1'b0, acc_q} <= lim) ? target : acc_q - {8'h0, adsr_di};
        end
        SUSTAIN: acc_d = target;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      gate_q <= 1'b0;
      sample_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      gate_q <= gate_d;
      sample_q <= sample_d;
    end
  end
endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: directed vectors and hand-written sequences for adsr_env with PRESCALE=4.
module tb_adsr_env;
  logic clk = 1'b0, rst = 1'b1, gate = 1'b0, mute = 1'b0;
  logic [7:0] adsr_ai = '0, adsr_di = '0, adsr_s = '0, adsr_ri = '0, sample_in = '0;
  logic [7:0] sample_out, env;
  logic active;
  logic [2:0] state;
  int n_cmp = 0, n_fail = 0, pc = 0;
  bit t;

  adsr_env #(.PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .gate(gate), .mute(mute),
    .adsr_ai(adsr_ai), .adsr_di(adsr_di), .adsr_s(adsr_s), .adsr_ri(adsr_ri),
    .sample_in(sample_in), .sample_out(sample_out), .env(env),
    .active(active), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s, sin, env, sout;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // one clock; reports whether that edge was a prescaler tick
  task automatic clk1(output bit was_tick);
    was_tick = (pc == 3) && !rst;
    @(posedge clk);
    pc = rst ? 0 : (pc == 3 ? 0 : pc + 1);
    #1;
  endtask

  task automatic ticks(input int n);
    int k = 0;
    bit w;
    while (k < n) begin
      clk1(w);
      if (w) k++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n = 0;
    bit w;
    while (state !== s && n < budget) begin
      clk1(w);
      n++;
    end
    chk(nm, state, s);
  endtask

  initial begin
    tbl[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE};
    tbl[1] = '{8'h40, 8'h80, 8'h40, 8'h20};
    tbl[2] = '{8'h00, 8'hFF, 8'h00, 8'h00};
    tbl[3] = '{8'h10, 8'h10, 8'h10, 8'h01};
    tbl[4] = '{8'hC0, 8'hC0, 8'hC0, 8'h90};
    tbl[5] = '{8'h80, 8'hFF, 8'h80, 8'h7F};
    clk1(t);
    clk1(t);
    rst = 1'b0;
    chk("reset", {env, sample_out, 5'(state), active}, 0);
    for (int i = 0; i < 100; i++) begin
      clk1(t);
      chk("idle", {env, sample_out, 5'(state), active}, 0);
    end
    adsr_di = 8'h40;
    adsr_s = 8'h80;
    gate = 1'b1;
    clk1(t);
    chk("attack_enter", {5'(state), active, env}, {5'd1, 1'b1, 8'h00});
    ticks(3);
    chk("ai0_hold", {5'(state), env}, {5'd1, 8'h00});
    adsr_ai = 8'h80;
    ticks(509);
    chk("attack_509", {5'(state), env}, {5'd1, 8'hFE});
    ticks(1);
    chk("attack_510", {5'(state), env}, {5'd1, 8'hFF});
    ticks(1);
    chk("attack_511", state, 3'd1);
    ticks(1);
    chk("attack_512", {5'(state), dut.acc_q}, {5'd2, 16'hFFFF});
    ticks(511);
    chk("decay_511", {5'(state), dut.acc_q}, {5'd2, 16'h803F});
    ticks(1);
    chk("decay_512", {5'(state), dut.acc_q, env}, {5'd3, 16'h8000, 8'h80});
    for (int i = 0; i < 6; i++) begin
      adsr_s = tbl[i].s;
      ticks(1);
      sample_in = tbl[i].sin;
      clk1(t);
      chk($sformatf("sus_vec%0d", i), {5'(state), env, sample_out}, {5'd3, tbl[i].env, tbl[i].sout});
    end
    adsr_ri = 8'hFF;
    gate = 1'b0;
    clk1(t);
    chk("release_enter", {5'(state), dut.acc_q}, {5'd4, 16'h8000});
    ticks(128);
    chk("release_128", {5'(state), dut.acc_q}, {5'd4, 16'h0080});
    ticks(1);
    chk("release_129", {5'(state), active, dut.acc_q}, {5'd0, 1'b0, 16'h0000});
    adsr_ai = 8'hFF;
    adsr_di = 8'hFF;
    gate = 1'b1;
    wait_state(3'd2, 2000, "fast_attack");
    wait_state(3'd3, 2000, "fast_decay");
    chk("fast_sustain", dut.acc_q, 16'h8000);
    adsr_ri = 8'h80;
    gate = 1'b0;
    clk1(t);
    chk("release2_enter", state, 3'd4);
    ticks(128);
    chk("release2_128", {5'(state), env}, {5'd4, 8'h40});
    gate = 1'b1;
    clk1(t);
    chk("retrigger", {5'(state), env}, {5'd1, 8'h40});
    wait_state(3'd3, 3000, "retrig_sustain");
    mute = 1'b1;
    clk1(t);
    chk("mute", {env, sample_out, 5'(state), active}, 0);
    repeat (6) clk1(t);
    chk("mute_hold", {env, 5'(state)}, 0);
    mute = 1'b0;
    clk1(t);
    chk("unmute_retrig", {5'(state), env}, {5'd1, 8'h00});
    ticks(3);
    chk("unmute_attack", {5'(state), dut.acc_q}, {5'd1, 16'h02FD});
    rst = 1'b1;
    clk1(t);
    chk("mid_rst", {env, sample_out, 5'(state), active}, 0);
    chk("mid_rst_acc", dut.acc_q, 16'h0000);
    rst = 1'b0;
    clk1(t);
    chk("post_rst_retrig", state, 3'd1);
    ticks(1);
    chk("post_rst_tick", dut.acc_q, 16'h00FF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
